rs_cdb_station: RTL
===================

Name: rs_cdb_station

Overview:
- Parametrised reservation station for the Tomasulo core; one instance per functional-unit class (add/sub/branch, mul/div, load/store).
- Holds issued instructions with operand values or producer ROB tags.
- Snoops the common data bus (CDB) to capture results, and dispatches one ready instruction per cycle to its execution unit over a valid/ready handshake.
- Adds tag-based wakeup, same-cycle CDB bypass, flush and occupancy reporting.

Parameters:
- NUM_ENTRIES, 3: number of station entries; must be 2 or more.
- DATA_W, 16: operand and result width.
- TAG_W, 3: ROB index width.
- FUNC_W, 4: function code width.

Ports:
- clk1  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- issue_valid  in  1  issue request.
- issue_ready  out  1  station can accept.
- issue_func  in  FUNC_W  function code.
- issue_rob  in  TAG_W  destination ROB index.
- issue_src1_rdy / issue_src2_rdy  in  1  operand value is valid.
- issue_src1_val / issue_src2_val  in  DATA_W  operand value.
- issue_src1_tag / issue_src2_tag  in  TAG_W  producer ROB index; used when rdy=0.
- cdb_valid  in  1  result broadcast.
- cdb_tag  in  TAG_W  ROB index of the result.
- cdb_data  in  DATA_W  result value.
- disp_valid  out  1  dispatch request.
- disp_ready  in  1  execution unit accepts.
- disp_func  out  FUNC_W  function code of the dispatched instruction.
- disp_rob  out  TAG_W  ROB index of the dispatched instruction.
- disp_op1 / disp_op2  out  DATA_W  operand values.
- flush  in  1  synchronous squash of all contents.
- occupancy  out  $clog2(NUM_ENTRIES+1)  number of busy entries.

Behaviour:
- Entry fields: busy, func, rob, and per source: rdy, val, tag.
- Reset (async, rst_n=0): all busy=0; disp_valid=0; disp_func, disp_rob, disp_op1, disp_op2 = 0; occupancy=0; issue_ready=1 once rst_n=1. Reset mid-operation drops every entry and the output register.
- issue_ready = (occupancy < NUM_ENTRIES). It is not raised by a dispatch in the same cycle.
- Issue fires on issue_valid && issue_ready and writes the lowest-index free entry.
- Same-cycle bypass: if cdb_valid and cdb_tag equals a source tag whose rdy=0, that source is stored rdy=1 with val=cdb_data.
- Wakeup: on every edge with cdb_valid, each busy entry source with rdy=0 and tag==cdb_tag captures cdb_data and sets rdy=1. All matching entries capture in the same cycle.
- Eligible entry: busy && src1.rdy && src2.rdy, evaluated from registered state.
  - An entry written or woken at edge t is eligible from edge t+1.
  - Minimum latency is 2 edges from issue to disp_valid.
- Select: lowest eligible index by default (see Optional Feature).
- Output register load condition: !disp_valid || disp_ready.
  - If the load condition holds and an entry is eligible: load its fields, set disp_valid=1, clear its busy on the same edge.
  - If the load condition holds and nothing is eligible: disp_valid=0.
  - While disp_valid && !disp_ready, all disp_* outputs hold stable.
- occupancy updates every edge:
  - +1 on issue.
  - -1 on load into the output register.
  - Both in one cycle leave it unchanged.
- Flush (highest priority after reset): next edge all busy=0, disp_valid=0, occupancy=0. Issue and CDB capture in that cycle are ignored.
- CDB tags that match no waiting source have no effect. Duplicate tag waits in different entries are legal.
- Func codes are opaque; the station never decodes them.

Optional Feature:
- Macro: RS_AGE_SELECT_EN.
- When defined:
  - Each entry carries an age of $clog2(NUM_ENTRIES) bits.
  - On issue the new entry gets age 0 and every other busy entry increments its age, saturating at NUM_ENTRIES-1.
  - Select picks the eligible entry with the largest age (oldest first); ties go to the lowest index.
- When undefined: no age storage; select is lowest eligible index.

Decomposition:
- Package rs_pkg: func code constants (ADD=4'b0000, SUB=4'b0001, MUL=4'b0010, DIV=4'b0011, LD=4'b0100, ST=4'b0101, BEQ=4'b0110, BNE=4'b0111), the rs_src_t typedef (rdy, val, tag) and the rs_entry_t typedef.
- Sub-module rs_select: combinational pick from an eligible vector (plus the age vector when RS_AGE_SELECT_EN is defined). Outputs found and index.

Test Plan:
- Issue ADD with both sources ready (op1=5, op2=7, rob=2), disp_ready=1 -> disp_valid at second edge with op1=5, op2=7, rob=2; occupancy returns to 0.
- Issue MUL with src1 waiting on tag=4; CDB tag=4, data=16'h0033 two cycles later -> disp_valid the edge after capture, disp_op1=16'h0033.
- Issue with src2 tag=1 while cdb_valid, tag=1, data=9 in the same cycle -> entry stored ready; dispatch with op2=9 on the next edge.
- Fill all 3 entries with disp_ready=0 -> issue_ready=0, occupancy=3, disp_* stable while stalled; raise disp_ready -> one dispatch per cycle, issue_ready returns.
- Assert flush with 2 busy entries and disp_valid=1 -> next edge occupancy=0, disp_valid=0; a late CDB tag match causes no dispatch.
- With RS_AGE_SELECT_EN defined: issue into entries 1 then 0 with both waiting on tag=6, wake both with one CDB broadcast -> entry 1 (older) dispatches first.

Source files
------------

// File: rtl/rs_cdb_station_pkg.sv
// Shared types and constants for the reservation-station slice.
//
// Contents:
//   RS_DATA_W / RS_TAG_W / RS_FUNC_W  widths that size the entry structs
//   ADD..BNE                          function-code constants (opaque to the station)
//   rs_src_t                          one source operand: rdy, val, tag
//   rs_entry_t                        one station entry: busy, func, rob, src1, src2
//   capture_src()                     CDB snoop of a single source operand
package rs_pkg;

   localparam int RS_DATA_W = 16;
   localparam int RS_TAG_W  = 3;
   localparam int RS_FUNC_W = 4;

   localparam logic [RS_FUNC_W-1:0] ADD = 4'b0000;
   localparam logic [RS_FUNC_W-1:0] SUB = 4'b0001;
   localparam logic [RS_FUNC_W-1:0] MUL = 4'b0010;
   localparam logic [RS_FUNC_W-1:0] DIV = 4'b0011;
   localparam logic [RS_FUNC_W-1:0] LD  = 4'b0100;
   localparam logic [RS_FUNC_W-1:0] ST  = 4'b0101;
   localparam logic [RS_FUNC_W-1:0] BEQ = 4'b0110;
   localparam logic [RS_FUNC_W-1:0] BNE = 4'b0111;

   typedef struct packed {
      logic                 rdy;
      logic [RS_DATA_W-1:0] val;
      logic [RS_TAG_W-1:0]  tag;
   } rs_src_t;

   typedef struct packed {
      logic                 busy;
      logic [RS_FUNC_W-1:0] func;
      logic [RS_TAG_W-1:0]  rob;
      rs_src_t              src1;
      rs_src_t              src2;
   } rs_entry_t;

   // A waiting source picks up the broadcast value when the tag matches;
   // already-ready sources are left alone so a stale tag can never clobber them.
   function automatic rs_src_t capture_src(input rs_src_t              src,
                                           input logic                 cdb_valid,
                                           input logic [RS_TAG_W-1:0]  cdb_tag,
                                           input logic [RS_DATA_W-1:0] cdb_data);
      rs_src_t res;
      res = src;
      if (cdb_valid && !src.rdy && (src.tag == cdb_tag)) begin
         res.rdy = 1'b1;
         res.val = cdb_data;
      end
      return res;
   endfunction

endpackage

// File: rtl/rs_cdb_station_if.sv
// Bus bundle between the issue stage / CDB / execution unit and one
// reservation station.
//
// modport slave  : the station (consumes issue + CDB, produces dispatch)
// modport master : whoever drives issue, CDB, dispatch-ready and flush
interface rs_cdb_station_if #(
   parameter int NUM_ENTRIES = 3,
   parameter int DATA_W      = 16,
   parameter int TAG_W       = 3,
   parameter int FUNC_W      = 4
);
   localparam int OCC_W = $clog2(NUM_ENTRIES + 1);

   logic              issue_valid;
   logic              issue_ready;
   logic [FUNC_W-1:0] issue_func;
   logic [TAG_W-1:0]  issue_rob;
   logic              issue_src1_rdy;
   logic              issue_src2_rdy;
   logic [DATA_W-1:0] issue_src1_val;
   logic [DATA_W-1:0] issue_src2_val;
   logic [TAG_W-1:0]  issue_src1_tag;
   logic [TAG_W-1:0]  issue_src2_tag;

   logic              cdb_valid;
   logic [TAG_W-1:0]  cdb_tag;
   logic [DATA_W-1:0] cdb_data;

   logic              disp_valid;
   logic              disp_ready;
   logic [FUNC_W-1:0] disp_func;
   logic [TAG_W-1:0]  disp_rob;
   logic [DATA_W-1:0] disp_op1;
   logic [DATA_W-1:0] disp_op2;

   logic              flush;
   logic [OCC_W-1:0]  occupancy;

   modport slave (
      input  issue_valid, issue_func, issue_rob,
             issue_src1_rdy, issue_src2_rdy, issue_src1_val, issue_src2_val,
             issue_src1_tag, issue_src2_tag,
             cdb_valid, cdb_tag, cdb_data, disp_ready, flush,
      output issue_ready, disp_valid, disp_func, disp_rob, disp_op1, disp_op2,
             occupancy
   );

   modport master (
      output issue_valid, issue_func, issue_rob,
             issue_src1_rdy, issue_src2_rdy, issue_src1_val, issue_src2_val,
             issue_src1_tag, issue_src2_tag,
             cdb_valid, cdb_tag, cdb_data, disp_ready, flush,
      input  issue_ready, disp_valid, disp_func, disp_rob, disp_op1, disp_op2,
             occupancy
   );

endinterface

// File: rtl/rs_cdb_station_select.sv
// rs_select: combinational pick of one entry from an eligible vector.
//
// Ports:
//   eligible  in  N         one bit per entry that may dispatch
//   age       in  N x IDX_W entry ages (only with RS_AGE_SELECT_EN)
//   found     out 1         at least one entry is eligible
//   index     out IDX_W     chosen entry
//
// Build option RS_AGE_SELECT_EN: oldest eligible entry wins, ties to the
// lowest index. Without it the lowest eligible index wins.
module rs_select #(
   parameter int N     = 3,
   parameter int IDX_W = 2
) (
   input  logic [N-1:0]     eligible,
`ifdef RS_AGE_SELECT_EN
   input  logic [IDX_W-1:0] age [N],
`endif
   output logic             found,
   output logic [IDX_W-1:0] index
);

`ifdef RS_AGE_SELECT_EN
   logic [IDX_W-1:0] best_age;

   // Ascending scan with a strict greater-than keeps the lowest index on ties.
   always_comb begin
      found    = 1'b0;
      index    = '0;
      best_age = '0;
      for (int i = 0; i < N; i++) begin
         if (eligible[i] && (!found || (age[i] > best_age))) begin
            found    = 1'b1;
            index    = IDX_W'(i);
            best_age = age[i];
         end
      end
   end
`else
   // Descending scan so the last hit written is the lowest index.
   always_comb begin
      found = 1'b0;
      index = '0;
      for (int i = N - 1; i >= 0; i--) begin
         if (eligible[i]) begin
            found = 1'b1;
            index = IDX_W'(i);
         end
      end
   end
`endif

endmodule

// File: rtl/rs_cdb_station.sv
// rs_cdb_station: reservation station that holds issued instructions, snoops
// the CDB for missing operands and dispatches one ready instruction per cycle
// through a registered valid/ready output stage.
//
// Ports:
//   clk1   in  rising-edge clock
//   rst_n  in  asynchronous active-low reset
//   bus    rs_cdb_station_if.slave: issue request/ready and operands, CDB
//          broadcast, dispatch valid/ready and fields, flush, occupancy
//
// Build option RS_AGE_SELECT_EN: track per-entry age and dispatch oldest first.
// Entry storage uses rs_pkg structs, so DATA_W/TAG_W/FUNC_W must match the
// RS_*_W widths in the package.
module rs_cdb_station
   import rs_pkg::*;
#(
   parameter int NUM_ENTRIES = 3,
   parameter int DATA_W      = RS_DATA_W,
   parameter int TAG_W       = RS_TAG_W,
   parameter int FUNC_W      = RS_FUNC_W
) (
   input  logic             clk1,
   input  logic             rst_n,
   rs_cdb_station_if.slave  bus
);

   localparam int IDX_W = $clog2(NUM_ENTRIES);
   localparam int OCC_W = $clog2(NUM_ENTRIES + 1);

   rs_entry_t         entries_q [NUM_ENTRIES];
   rs_entry_t         entries_d [NUM_ENTRIES];
`ifdef RS_AGE_SELECT_EN
   logic [IDX_W-1:0]  age_q [NUM_ENTRIES];
   logic [IDX_W-1:0]  age_d [NUM_ENTRIES];
`endif
   logic [OCC_W-1:0]  occ_q, occ_d;
   logic              disp_valid_q, disp_valid_d;
   logic [FUNC_W-1:0] disp_func_q, disp_func_d;
   logic [TAG_W-1:0]  disp_rob_q, disp_rob_d;
   logic [DATA_W-1:0] disp_op1_q, disp_op1_d;
   logic [DATA_W-1:0] disp_op2_q, disp_op2_d;

   logic [NUM_ENTRIES-1:0] eligible;
   logic                   sel_found;
   logic [IDX_W-1:0]       sel_idx;
   logic [IDX_W-1:0]       free_idx;
   logic                   issue_ready, do_issue, load_en, do_disp;
   rs_entry_t              new_entry;

   // Eligibility looks only at registered state, so anything written or woken
   // this edge waits one more cycle before it can be picked.
   always_comb begin
      eligible = '0;
      for (int i = 0; i < NUM_ENTRIES; i++) begin
         eligible[i] = entries_q[i].busy && entries_q[i].src1.rdy && entries_q[i].src2.rdy;
      end
   end

   rs_select #(.N(NUM_ENTRIES), .IDX_W(IDX_W)) u_select (
      .eligible (eligible),
`ifdef RS_AGE_SELECT_EN
      .age      (age_q),
`endif
      .found    (sel_found),
      .index    (sel_idx)
   );

   // Lowest-index free slot; only used when occupancy guarantees one exists.
   always_comb begin
      free_idx = '0;
      for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
         if (!entries_q[i].busy) free_idx = IDX_W'(i);
      end
   end

   // A dispatch in the same cycle does not free a slot for issue.
   assign issue_ready = (occ_q < OCC_W'(NUM_ENTRIES));
   assign do_issue    = bus.issue_valid && issue_ready;
   assign load_en     = !disp_valid_q || bus.disp_ready;
   assign do_disp     = load_en && sel_found;

   // Incoming entry with the same-cycle CDB bypass already applied.
   always_comb begin
      new_entry      = '0;
      new_entry.busy = 1'b1;
      new_entry.func = bus.issue_func;
      new_entry.rob  = bus.issue_rob;
      new_entry.src1 = capture_src('{rdy: bus.issue_src1_rdy, val: bus.issue_src1_val,
                                     tag: bus.issue_src1_tag},
                                   bus.cdb_valid, bus.cdb_tag, bus.cdb_data);
      new_entry.src2 = capture_src('{rdy: bus.issue_src2_rdy, val: bus.issue_src2_val,
                                     tag: bus.issue_src2_tag},
                                   bus.cdb_valid, bus.cdb_tag, bus.cdb_data);
   end

   // Next-state: flush wins; otherwise wakeup, dispatch-clear, then issue-write.
   always_comb begin
      entries_d    = entries_q;
`ifdef RS_AGE_SELECT_EN
      age_d        = age_q;
`endif
      occ_d        = occ_q;
      disp_valid_d = disp_valid_q;
      disp_func_d  = disp_func_q;
      disp_rob_d   = disp_rob_q;
      disp_op1_d   = disp_op1_q;
      disp_op2_d   = disp_op2_q;

      if (bus.flush) begin
         for (int i = 0; i < NUM_ENTRIES; i++) entries_d[i].busy = 1'b0;
         disp_valid_d = 1'b0;
         occ_d        = '0;
      end else begin
         for (int i = 0; i < NUM_ENTRIES; i++) begin
            if (entries_q[i].busy) begin
               entries_d[i].src1 = capture_src(entries_q[i].src1, bus.cdb_valid,
                                               bus.cdb_tag, bus.cdb_data);
               entries_d[i].src2 = capture_src(entries_q[i].src2, bus.cdb_valid,
                                               bus.cdb_tag, bus.cdb_data);
            end
         end

         if (load_en) begin
            disp_valid_d = sel_found;
            if (sel_found) begin
               disp_func_d              = entries_q[sel_idx].func;
               disp_rob_d               = entries_q[sel_idx].rob;
               disp_op1_d               = entries_q[sel_idx].src1.val;
               disp_op2_d               = entries_q[sel_idx].src2.val;
               entries_d[sel_idx].busy  = 1'b0;
            end
         end

         if (do_issue) begin
`ifdef RS_AGE_SELECT_EN
            for (int i = 0; i < NUM_ENTRIES; i++) begin
               if (entries_q[i].busy && (age_q[i] != IDX_W'(NUM_ENTRIES - 1)))
                  age_d[i] = age_q[i] + 1'b1;
            end
            age_d[free_idx] = '0;
`endif
            entries_d[free_idx] = new_entry;
         end

         occ_d = occ_q + OCC_W'(do_issue) - OCC_W'(do_disp);
      end
   end

   // State registers; reset drops every entry and the output stage.
   always_ff @(posedge clk1 or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_ENTRIES; i++) begin
            entries_q[i] <= '0;
`ifdef RS_AGE_SELECT_EN
            age_q[i]     <= '0;
`endif
         end
         occ_q        <= '0;
         disp_valid_q <= 1'b0;
         disp_func_q  <= '0;
         disp_rob_q   <= '0;
         disp_op1_q   <= '0;
         disp_op2_q   <= '0;
      end else begin
         entries_q    <= entries_d;
`ifdef RS_AGE_SELECT_EN
         age_q        <= age_d;
`endif
         occ_q        <= occ_d;
         disp_valid_q <= disp_valid_d;
         disp_func_q  <= disp_func_d;
         disp_rob_q   <= disp_rob_d;
         disp_op1_q   <= disp_op1_d;
         disp_op2_q   <= disp_op2_d;
      end
   end

   assign bus.issue_ready = issue_ready;
   assign bus.disp_valid  = disp_valid_q;
   assign bus.disp_func   = disp_func_q;
   assign bus.disp_rob    = disp_rob_q;
   assign bus.disp_op1    = disp_op1_q;
   assign bus.disp_op2    = disp_op2_q;
   assign bus.occupancy   = occ_q;

endmodule
